// File: rtl/kerygma_soc.sv
// Debug-controlled SoC shell: a UART debug master (udm) drives a one-cycle 32-bit bus
// that reaches a word RAM, the LED/switch CSRs and a button IRQ latch.

module kerygma_udm #(
  parameter string RTX_EXTERNAL_OVERRIDE = "NO",
  parameter int    CLK_DIV               = 868
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_CMD  = 3'd1;
  localparam logic [2:0] P_ADDR = 3'd2;
  localparam logic [2:0] P_DATA = 3'd3;
  localparam logic [2:0] P_EXEC = 3'd4;
  localparam logic [2:0] P_RESP = 3'd5;

  localparam logic [7:0] CMD_RD32  = 8'h01;
  localparam logic [7:0] CMD_WR32  = 8'h02;
  localparam logic [7:0] CMD_CHECK = 8'h03;

  logic [15:0] bit_period;

  // In override mode bit_period is a self-holding register so a bench can force it
  generate
    if (RTX_EXTERNAL_OVERRIDE == "YES") begin : g_bp_reg
      always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) bit_period <= 16'(CLK_DIV);
        else         bit_period <= bit_period;
      end
    end else begin : g_bp_const
      assign bit_period = 16'(CLK_DIV);
    end
  endgenerate

  logic [15:0] bit_half, bit_last;
  assign bit_half = bit_period >> 1;
  assign bit_last = bit_period - 16'd1;

  logic [1:0]  rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_prev_q, rx_prev_d;
  logic        rx_valid, rx_err;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_prev_d  = rx_i;
    rx_valid   = 1'b0;
    rx_err     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_i) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == bit_half) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_i ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == bit_last) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_i, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: begin
        if (rx_cnt_q == bit_last) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_valid   = rx_i;
          rx_err     = !rx_i;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
    endcase
  end

  logic [2:0]  p_state_q, p_state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] resp_q, resp_d;
  logic [1:0]  resp_cnt_q, resp_cnt_d;
  logic        resp_push;

  // A broken stop bit aborts whatever frame the parser was assembling
  always_comb begin
    p_state_d  = p_state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    byte_cnt_d = byte_cnt_q;
    resp_d     = resp_q;
    resp_cnt_d = resp_cnt_q;
    resp_push  = 1'b0;
    bus_req_o  = 1'b0;
    bus_we_o   = 1'b0;
    if (rx_err) begin
      p_state_d = P_IDLE;
    end else begin
      case (p_state_q)
        P_IDLE: if (rx_valid && rx_shift_q == 8'h55) p_state_d = P_CMD;
        P_CMD: begin
          if (rx_valid) begin
            cmd_d      = rx_shift_q;
            byte_cnt_d = '0;
            case (rx_shift_q)
              CMD_RD32, CMD_WR32: p_state_d = P_ADDR;
              CMD_CHECK:          p_state_d = P_EXEC;
              default:            p_state_d = P_IDLE;
            endcase
          end
        end
        P_ADDR: begin
          if (rx_valid) begin
            addr_d     = {rx_shift_q, addr_q[31:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) p_state_d = (cmd_q == CMD_WR32) ? P_DATA : P_EXEC;
          end
        end
        P_DATA: begin
          if (rx_valid) begin
            data_d     = {rx_shift_q, data_q[31:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) p_state_d = P_EXEC;
          end
        end
        P_EXEC: begin
          bus_req_o  = (cmd_q != CMD_CHECK);
          bus_we_o   = (cmd_q == CMD_WR32);
          resp_d     = (cmd_q == CMD_RD32) ? bus_rdata_i :
                       (cmd_q == CMD_WR32) ? 32'h0 : 32'h55;
          resp_cnt_d = (cmd_q == CMD_RD32) ? 2'd3 : 2'd0;
          p_state_d  = P_RESP;
        end
        P_RESP: begin
          resp_push  = 1'b1;
          resp_d     = {8'h00, resp_q[31:8]};
          resp_cnt_d = resp_cnt_q - 2'd1;
          if (resp_cnt_q == 2'd0) p_state_d = P_IDLE;
        end
        default: p_state_d = P_IDLE;
      endcase
    end
  end

  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = data_q;

  logic [3:0][7:0] fifo_mem_q, fifo_mem_d;
  logic [1:0]      fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [2:0]      fifo_cnt_q, fifo_cnt_d;
  logic [9:0]      tx_shift_q, tx_shift_d;
  logic [3:0]      tx_bits_q, tx_bits_d;
  logic [15:0]     tx_cnt_q, tx_cnt_d;
  logic            push_ok, tx_load;

  // Reply bytes arriving while the FIFO is full are dropped
  assign push_ok = resp_push && (fifo_cnt_q != 3'd4);
  assign tx_load = (tx_bits_q == 4'd0) && (fifo_cnt_q != 3'd0);

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_bits_d  = tx_bits_q;
    tx_cnt_d   = tx_cnt_q;
    if (push_ok) begin
      fifo_mem_d[fifo_wr_q] = resp_q[7:0];
      fifo_wr_d             = fifo_wr_q + 2'd1;
    end
    case ({push_ok, tx_load})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (tx_load) begin
      fifo_rd_d  = fifo_rd_q + 2'd1;
      tx_shift_d = {1'b1, fifo_mem_q[fifo_rd_q], 1'b0};
      tx_bits_d  = 4'd10;
      tx_cnt_d   = '0;
    end else if (tx_bits_q != 4'd0) begin
      if (tx_cnt_q == bit_last) begin
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bits_d  = tx_bits_q - 4'd1;
        tx_cnt_d   = '0;
      end else begin
        tx_cnt_d = tx_cnt_q + 16'd1;
      end
    end
  end

  assign tx_o = tx_shift_q[0];

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_prev_q  <= 1'b1;
      p_state_q  <= P_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      byte_cnt_q <= '0;
      resp_q     <= '0;
      resp_cnt_q <= '0;
      fifo_mem_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
      tx_shift_q <= '1;
      tx_bits_q  <= '0;
      tx_cnt_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_prev_q  <= rx_prev_d;
      p_state_q  <= p_state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      byte_cnt_q <= byte_cnt_d;
      resp_q     <= resp_d;
      resp_cnt_q <= resp_cnt_d;
      fifo_mem_q <= fifo_mem_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_bits_q  <= tx_bits_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

endmodule

module kerygma_soc #(
  parameter string UDM_RTX_EXTERNAL_OVERRIDE = "NO",
  parameter int    UDM_CLK_DIV               = 868,
  parameter string mem_init_type             = "none",
  parameter string mem_init_data             = "",
  parameter int    mem_size                  = 8192
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        irq_btn_i,
  input  logic        rx_i,
  output logic        tx_o,
  input  logic [31:0] gpio_bi,
  output logic [31:0] gpio_bo
);

  localparam int ADDR_W = $clog2(mem_size);
  localparam int WORDS  = mem_size / 4;

  logic        rx_meta_q, rx_sync_q;
  logic        btn_meta_q, btn_sync_q, btn_prev_q;
  logic [31:0] gpio_meta_q, gpio_sync_q;
  logic [31:0] led_q, led_d;
  logic        irq_q, irq_d;

  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  kerygma_udm #(
    .RTX_EXTERNAL_OVERRIDE(UDM_RTX_EXTERNAL_OVERRIDE),
    .CLK_DIV              (UDM_CLK_DIV)
  ) udm (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .rx_i       (rx_sync_q),
    .tx_o       (tx_o),
    .bus_req_o  (bus_req),
    .bus_we_o   (bus_we),
    .bus_addr_o (bus_addr),
    .bus_wdata_o(bus_wdata),
    .bus_rdata_i(bus_rdata)
  );

  logic [31:0] ram_mem [WORDS];

  logic                ram_sel, led_sel, sw_sel, irq_sel, bus_wr;
  logic [ADDR_W-3:0]   ram_idx;
  logic                unused_addr_lsbs;

  // Byte lane bits are ignored; RAM addresses above mem_size wrap onto the same words
  assign ram_sel          = !bus_addr[31];
  assign led_sel          = (bus_addr[31:2] == 30'h2000_0000);
  assign sw_sel           = (bus_addr[31:2] == 30'h2000_0001);
  assign irq_sel          = (bus_addr[31:2] == 30'h2000_0002);
  assign ram_idx          = bus_addr[ADDR_W-1:2];
  assign bus_wr           = bus_req && bus_we;
  assign unused_addr_lsbs = ^bus_addr[1:0];

  always_comb begin
    bus_rdata = '0;
    if (ram_sel)      bus_rdata = ram_mem[ram_idx];
    else if (led_sel) bus_rdata = led_q;
    else if (sw_sel)  bus_rdata = gpio_sync_q;
    else if (irq_sel) bus_rdata = {31'h0, irq_q};
  end

  always_ff @(posedge clk_i) begin
    if (bus_wr && ram_sel) ram_mem[ram_idx] <= bus_wdata;
  end

  // A button edge in the same cycle as a software clear keeps the latch set
  always_comb begin
    led_d = (bus_wr && led_sel) ? bus_wdata : led_q;
    irq_d = (btn_sync_q && !btn_prev_q) ||
            (irq_q && !(bus_wr && irq_sel && bus_wdata[0]));
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      btn_prev_q  <= 1'b0;
      gpio_meta_q <= '0;
      gpio_sync_q <= '0;
      led_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_sync_q   <= rx_meta_q;
      btn_meta_q  <= irq_btn_i;
      btn_sync_q  <= btn_meta_q;
      btn_prev_q  <= btn_sync_q;
      gpio_meta_q <= gpio_bi;
      gpio_sync_q <= gpio_meta_q;
      led_q       <= led_d;
      irq_q       <= irq_d;
    end
  end

  assign gpio_bo = led_q;

endmodule

// File: tb/tb_kerygma_soc.sv
// Directed bench for kerygma_soc: drives UART command frames on rx_i and decodes
// replies from tx_o with a fast bit period.

module tb_kerygma_soc;

  localparam int BIT   = 16;
  localparam int FRAME = BIT * 10;

  logic        clk_i     = 1'b0;
  logic        arst_i    = 1'b1;
  logic        irq_btn_i = 1'b0;
  logic        rx_i      = 1'b1;
  logic        tx_o;
  logic [31:0] gpio_bi   = '0;
  logic [31:0] gpio_bo;

  int assertCount  = 0;
  int failCount    = 0;
  int txStopErrors = 0;
  logic [7:0] rxQ [$];

  always #5 clk_i = ~clk_i;

  kerygma_soc #(.UDM_CLK_DIV(BIT)) dut (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .irq_btn_i(irq_btn_i),
    .rx_i     (rx_i),
    .tx_o     (tx_o),
    .gpio_bi  (gpio_bi),
    .gpio_bo  (gpio_bo)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    @(negedge clk_i);
    rx_i = 1'b0;
    repeat (BIT) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = data[i];
      repeat (BIT) @(negedge clk_i);
    end
    rx_i = stopBit;
    repeat (BIT) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (BIT) @(negedge clk_i);
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8], 1'b1);
  endtask

  task automatic getByte(input string tag, output logic [7:0] b);
    int waited = 0;
    while (rxQ.size() == 0 && waited < 3 * FRAME) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput({tag, "_present"}, 32'(rxQ.size() != 0), 32'd1);
    b = (rxQ.size() != 0) ? rxQ.pop_front() : 8'h00;
  endtask

  task automatic rd32(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    logic [31:0] word;
    logic [7:0]  b;
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'h01, 1'b1);
    sendWord(addr);
    for (int i = 0; i < 4; i++) begin
      getByte(tag, b);
      word[8*i +: 8] = b;
    end
    checkOutput(tag, word, expected);
  endtask

  task automatic wr32(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic [7:0] b;
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'h02, 1'b1);
    sendWord(addr);
    sendWord(data);
    getByte(tag, b);
    checkOutput({tag, "_ack"}, {24'h0, b}, 32'h0);
  endtask

  // UART receiver on tx_o, sampling mid-bit on the falling clock edge
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk_i);
      if (arst_i && tx_o === 1'b0) begin
        repeat (BIT / 2) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk_i);
          b[i] = tx_o;
        end
        repeat (BIT) @(negedge clk_i);
        if (tx_o !== 1'b1) txStopErrors++;
        rxQ.push_back(b);
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk_i);
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    logic [7:0] b;

    #2 arst_i = 1'b0;
    repeat (10) @(negedge clk_i);
    checkOutput("reset_tx", {31'h0, tx_o}, 32'h1);
    checkOutput("reset_gpio", gpio_bo, 32'h0);
    arst_i = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1 || gpio_bo !== 32'h0) bad++;
    end
    checkOutput("idle_quiet", bad, 32'h0);

    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'h03, 1'b1);
    getByte("check", b);
    checkOutput("check_reply", {24'h0, b}, 32'h55);
    repeat (2 * FRAME) @(negedge clk_i);
    checkOutput("check_single", rxQ.size(), 32'h0);

    wr32("led_wr", 32'h8000_0000, 32'hdead_beef);
    repeat (2) @(negedge clk_i);
    checkOutput("led_out", gpio_bo, 32'hdead_beef);
    rd32("led_rd", 32'h8000_0000, 32'hdead_beef);
    rd32("led_rd_lsb", 32'h8000_0002, 32'hdead_beef);

    gpio_bi = 32'h30;
    rd32("sw_rd0", 32'h8000_0004, 32'h30);
    gpio_bi = gpio_bi + 32'h1;
    rd32("sw_rd1", 32'h8000_0004, 32'h31);

    wr32("ram_wr", 32'h0000_0010, 32'h1234_5678);
    rd32("ram_rd", 32'h0000_0010, 32'h1234_5678);
    rd32("ram_wrap", 32'h0000_2010, 32'h1234_5678);
    rd32("ram_lsb", 32'h0000_0013, 32'h1234_5678);
    wr32("ram_wr2", 32'h0000_0014, 32'ha5a5_a5a5);
    rd32("ram_rd2", 32'h0000_0014, 32'ha5a5_a5a5);
    rd32("ram_keep", 32'h0000_0010, 32'h1234_5678);
    rd32("unmapped", 32'h8000_0010, 32'h0);

    rd32("irq_idle", 32'h8000_0008, 32'h0);
    @(negedge clk_i);
    irq_btn_i = 1'b1;
    repeat (5) @(negedge clk_i);
    irq_btn_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rd32("irq_set", 32'h8000_0008, 32'h1);
    wr32("irq_clr", 32'h8000_0008, 32'h1);
    rd32("irq_cleared", 32'h8000_0008, 32'h0);

    applyStimulus(8'h55, 1'b0);
    applyStimulus(8'h03, 1'b1);
    repeat (3 * FRAME) @(negedge clk_i);
    checkOutput("badstop_silent", rxQ.size(), 32'h0);
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'h03, 1'b1);
    getByte("recover", b);
    checkOutput("recover_reply", {24'h0, b}, 32'h55);

    checkOutput("tx_stop_bits", txStopErrors, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
